// File: rtl/fpu_issue_ctrl.sv
// Issue sequencer for the combinational bf16 FPU: 2-cycle ops, MADD as MUL-then-ADD in 3.
// One request in flight; the response is held until rsp_ready_i, and the request side stalls meanwhile.
package ibex_pkg;
  typedef enum logic [3:0] {
    FP_ALU_ADD    = 4'd0,
    FP_ALU_SUB    = 4'd1,
    FP_ALU_MUL    = 4'd2,
    FP_ALU_MADD   = 4'd3,
    FP_ALU_MINMAX = 4'd4,
    FP_ALU_SGNJ   = 4'd5,
    FP_ALU_CMP    = 4'd6,
    FP_ALU_CVT    = 4'd7,
    FP_ALU_CLASS  = 4'd8
  } fp_alu_op_e;
endpackage

module fpu_issue_ctrl
  import ibex_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  fp_alu_op_e  req_op_i,
  input  logic [1:0]  req_mode_i,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  input  logic [31:0] req_c_i,
  input  logic [4:0]  req_tag_i,
  output fp_alu_op_e  fpu_operator_o,
  output logic [31:0] fpu_operand_a_o,
  output logic [15:0] fpu_operand_b_o,
  output logic [1:0]  fpu_mode_o,
  input  logic [31:0] fpu_result_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic [4:0]  rsp_tag_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, EXEC, MADD2, RESP} state_e;

  state_e      state_q, state_d;
  fp_alu_op_e  op_q;
  logic [1:0]  mode_q;
  logic [31:0] a_q;
  logic [15:0] b_q, c_q, prod_q;
  logic [4:0]  tag_q;
  logic [31:0] result_q;
  logic        accept;
  logic        unused_lo;

  // Only the bf16 upper halves of B and C are meaningful.
  assign unused_lo = ^{req_b_i[15:0], req_c_i[15:0]};

  assign req_ready_o = !flush_i && rst_ni &&
                       ((state_q == IDLE) || ((state_q == RESP) && rsp_ready_i));
  assign accept      = req_valid_i && req_ready_o;

  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_result_o = result_q;
  assign rsp_tag_o    = tag_q;
  assign busy_o       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = EXEC;
      EXEC:  state_d = (op_q == FP_ALU_MADD) ? MADD2 : RESP;
      MADD2: state_d = RESP;
      RESP:  if (rsp_ready_i) state_d = accept ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // FPU inputs are muxed purely from registered state so each cycle sees one FPU traversal.
  always_comb begin
    fpu_operator_o  = FP_ALU_ADD;
    fpu_operand_a_o = 32'h0;
    fpu_operand_b_o = 16'h0;
    fpu_mode_o      = 2'b00;
    if (state_q == EXEC) begin
      if (op_q == FP_ALU_MADD) begin
        fpu_operator_o  = FP_ALU_MUL;
        fpu_operand_a_o = a_q;
        fpu_operand_b_o = b_q;
      end else begin
        fpu_operator_o  = op_q;
        fpu_operand_a_o = a_q;
        fpu_operand_b_o = b_q;
        fpu_mode_o      = mode_q;
      end
    end else if (state_q == MADD2) begin
      fpu_operator_o  = FP_ALU_ADD;
      fpu_operand_a_o = {prod_q, 16'h0};
      fpu_operand_b_o = c_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      op_q     <= FP_ALU_ADD;
      mode_q   <= 2'b00;
      a_q      <= 32'h0;
      b_q      <= 16'h0;
      c_q      <= 16'h0;
      prod_q   <= 16'h0;
      tag_q    <= 5'h0;
      result_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= req_op_i;
        mode_q <= req_mode_i;
        a_q    <= req_a_i;
        b_q    <= req_b_i[31:16];
        c_q    <= req_c_i[31:16];
        tag_q  <= req_tag_i;
      end
      if (!flush_i) begin
        if (state_q == EXEC) begin
          if (op_q == FP_ALU_MADD) prod_q   <= fpu_result_i[31:16];
          else                     result_q <= fpu_result_i;
        end else if (state_q == MADD2) begin
          result_q <= fpu_result_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a stand-in FPU and an expected-response queue.
module tb_fpu_issue_ctrl;
  import ibex_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  fp_alu_op_e  req_op_i = FP_ALU_ADD;
  logic [1:0]  req_mode_i = 2'b00;
  logic [31:0] req_a_i = 32'h0, req_b_i = 32'h0, req_c_i = 32'h0;
  logic [4:0]  req_tag_i = 5'h0;
  fp_alu_op_e  fpu_operator_o;
  logic [31:0] fpu_operand_a_o;
  logic [15:0] fpu_operand_b_o;
  logic [1:0]  fpu_mode_o;
  logic [31:0] fpu_result_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_result_o;
  logic [4:0]  rsp_tag_o;
  logic        busy_o;

  typedef struct packed { logic [4:0] tag; logic [31:0] res; } exp_t;
  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_mode_i(req_mode_i), .req_a_i(req_a_i), .req_b_i(req_b_i), .req_c_i(req_c_i),
    .req_tag_i(req_tag_i), .fpu_operator_o(fpu_operator_o), .fpu_operand_a_o(fpu_operand_a_o),
    .fpu_operand_b_o(fpu_operand_b_o), .fpu_mode_o(fpu_mode_o), .fpu_result_i(fpu_result_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .rsp_tag_o(rsp_tag_o), .busy_o(busy_o)
  );

  // Stand-in FPU: exact answers for the known arithmetic cases, an input-dependent hash otherwise.
  function automatic logic [31:0] fake_fpu(fp_alu_op_e op, logic [31:0] a, logic [15:0] b, logic [1:0] m);
    if (op == FP_ALU_ADD && a == 32'h3F800000 && b == 16'h4000) return 32'h40400000;
    if (op == FP_ALU_MUL && a == 32'h40000000 && b == 16'h4040) return 32'h40C00000;
    if (op == FP_ALU_ADD && a == 32'h40C00000 && b == 16'h3F80) return 32'h40E00000;
    return {b ^ a[31:16], a[15:0] ^ {12'h0, op}} ^ {m, 30'h0};
  endfunction

  assign fpu_result_i = fake_fpu(fpu_operator_o, fpu_operand_a_o, fpu_operand_b_o, fpu_mode_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input fp_alu_op_e op, input logic [1:0] m, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c, input logic [4:0] t);
    req_valid_i = 1'b1;
    req_op_i = op; req_mode_i = m; req_a_i = a; req_b_i = b; req_c_i = c; req_tag_i = t;
  endtask

  task automatic push(input logic [4:0] t, input logic [31:0] r);
    exp_t e;
    e.tag = t; e.res = r;
    sb.push_back(e);
  endtask

  task automatic rsp_check(input string name);
    exp_t e;
    chk({name, "_valid"}, {31'h0, rsp_valid_o}, 32'h1);
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'h0, 32'h1);
    end else begin
      e = sb.pop_front();
      chk({name, "_result"}, rsp_result_o, e.res);
      chk({name, "_tag"}, {27'h0, rsp_tag_o}, {27'h0, e.tag});
    end
  endtask

  initial begin
    logic [31:0] cls_exp;
    // Reset state
    step(); step();
    chk("rst_valid", {31'h0, rsp_valid_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_ready", {31'h0, req_ready_o}, 32'h0);
    chk("rst_result", rsp_result_o, 32'h0);
    chk("rst_tag", {27'h0, rsp_tag_o}, 32'h0);
    chk("rst_fpu_op", {28'h0, fpu_operator_o}, 32'h0);
    chk("rst_fpu_a", fpu_operand_a_o, 32'h0);
    rst_ni = 1'b1;
    #1;
    chk("post_rst_ready", {31'h0, req_ready_o}, 32'h1);

    // ADD 1.0 + 2.0
    rsp_ready_i = 1'b1;
    drive(FP_ALU_ADD, 2'b00, 32'h3F800000, 32'h40000000, 32'h0, 5'd3);
    push(5'd3, 32'h40400000);
    step();
    req_valid_i = 1'b0;
    chk("add_exec_op", {28'h0, fpu_operator_o}, {28'h0, FP_ALU_ADD});
    chk("add_exec_b", {16'h0, fpu_operand_b_o}, 32'h4000);
    chk("add_exec_a", fpu_operand_a_o, 32'h3F800000);
    chk("add_exec_nvalid", {31'h0, rsp_valid_o}, 32'h0);
    chk("add_exec_busy", {31'h0, busy_o}, 32'h1);
    step();
    rsp_check("add");
    step();
    chk("add_idle", {31'h0, rsp_valid_o}, 32'h0);

    // MADD 2.0*3.0+1.0, mode forced to 0 on both passes
    drive(FP_ALU_MADD, 2'b11, 32'h40000000, 32'h40400000, 32'h3F800000, 5'd4);
    push(5'd4, 32'h40E00000);
    step();
    req_valid_i = 1'b0;
    chk("madd_p1_op", {28'h0, fpu_operator_o}, {28'h0, FP_ALU_MUL});
    chk("madd_p1_a", fpu_operand_a_o, 32'h40000000);
    chk("madd_p1_b", {16'h0, fpu_operand_b_o}, 32'h4040);
    chk("madd_p1_mode", {30'h0, fpu_mode_o}, 32'h0);
    step();
    chk("madd_p2_op", {28'h0, fpu_operator_o}, {28'h0, FP_ALU_ADD});
    chk("madd_p2_a", fpu_operand_a_o, 32'h40C00000);
    chk("madd_p2_b", {16'h0, fpu_operand_b_o}, 32'h3F80);
    chk("madd_p2_mode", {30'h0, fpu_mode_o}, 32'h0);
    chk("madd_p2_nvalid", {31'h0, rsp_valid_o}, 32'h0);
    step();
    rsp_check("madd");
    step();

    // CLASS under 5 cycles of backpressure
    rsp_ready_i = 1'b0;
    cls_exp = fake_fpu(FP_ALU_CLASS, 32'h7F800000, 16'h0, 2'b01);
    drive(FP_ALU_CLASS, 2'b01, 32'h7F800000, 32'h0, 32'h0, 5'd7);
    push(5'd7, cls_exp);
    step();
    req_valid_i = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'h0, rsp_valid_o}, 32'h1);
      chk("bp_result", rsp_result_o, cls_exp);
      chk("bp_ready", {31'h0, req_ready_o}, 32'h0);
      step();
    end
    rsp_ready_i = 1'b1;
    rsp_check("bp_release");
    step();
    chk("bp_single_hs", {31'h0, rsp_valid_o}, 32'h0);

    // Three back-to-back SUBs
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a, b;
      a = 32'h41000000 + 32'(i) * 32'h00230011;
      b = 32'h3E800000 + 32'(i) * 32'h01050000;
      drive(FP_ALU_SUB, 2'(i), a, b, 32'h0, 5'(10 + i));
      chk("b2b_ready", {31'h0, req_ready_o}, 32'h1);
      push(5'(10 + i), fake_fpu(FP_ALU_SUB, a, b[31:16], 2'(i)));
      step();
      chk("b2b_exec_nvalid", {31'h0, rsp_valid_o}, 32'h0);
      step();
      if (i == 2) req_valid_i = 1'b0;
      rsp_check("b2b");
    end
    step();
    chk("b2b_idle", {31'h0, busy_o}, 32'h0);

    // Undefined opcode passes straight through
    drive(fp_alu_op_e'(4'hD), 2'b10, 32'h12345678, 32'hABCD0000, 32'h0, 5'd2);
    push(5'd2, fake_fpu(fp_alu_op_e'(4'hD), 32'h12345678, 16'hABCD, 2'b10));
    step();
    req_valid_i = 1'b0;
    chk("undef_op", {28'h0, fpu_operator_o}, 32'hD);
    step();
    rsp_check("undef");
    step();

    // Flush during MADD2, then a normal ADD
    drive(FP_ALU_MADD, 2'b00, 32'h40000000, 32'h40400000, 32'h3F800000, 5'd5);
    step();
    req_valid_i = 1'b0;
    step();
    flush_i = 1'b1;
    #1;
    chk("flush_ready", {31'h0, req_ready_o}, 32'h0);
    step();
    flush_i = 1'b0;
    chk("flush_idle", {31'h0, busy_o}, 32'h0);
    chk("flush_nvalid", {31'h0, rsp_valid_o}, 32'h0);
    step();
    chk("flush_nvalid2", {31'h0, rsp_valid_o}, 32'h0);
    drive(FP_ALU_ADD, 2'b00, 32'h3F800000, 32'h40000000, 32'h0, 5'd6);
    push(5'd6, 32'h40400000);
    step();
    req_valid_i = 1'b0;
    step();
    rsp_check("post_flush_add");
    step();

    // Reset mid-EXEC
    drive(FP_ALU_ADD, 2'b00, 32'h3F800000, 32'h40000000, 32'h0, 5'd9);
    step();
    req_valid_i = 1'b0;
    rst_ni = 1'b0;
    step();
    chk("mrst_valid", {31'h0, rsp_valid_o}, 32'h0);
    chk("mrst_busy", {31'h0, busy_o}, 32'h0);
    chk("mrst_result", rsp_result_o, 32'h0);
    chk("mrst_tag", {27'h0, rsp_tag_o}, 32'h0);
    chk("mrst_fpu_a", fpu_operand_a_o, 32'h0);
    chk("mrst_ready", {31'h0, req_ready_o}, 32'h0);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mrst_no_stale", {31'h0, rsp_valid_o}, 32'h0);
    end
    chk("sb_drained", sb.size(), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Sequencing front-end that issues requests into the combinational bfloat16 FPU and returns results to the core over a valid/ready handshake. It registers one request at a time, drives the FPU operator/operand/mode inputs, and captures `result_o`. FP_ALU_MADD, which the FPU does not implement, is built here as a two-pass MUL-then-ADD sequence. It sits between the ibex ID/EX issue logic and the FPU instance.

## Interface
- No parameters.
- `clk_i` in 1: core clock.
- `rst_ni` in 1: reset, synchronous and active-low.
- `flush_i` in 1: discard any in-flight request.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: request accepted when high with `req_valid_i`.
- `req_op_i` in `ibex_pkg::fp_alu_op_e`: operation.
- `req_mode_i` in 2: mode, passed to the FPU unchanged.
- `req_a_i` in 32: operand A, bf16 in [31:16], or a 32-bit integer for CVT with mode[1]=1.
- `req_b_i` in 32: operand B, bf16 in [31:16].
- `req_c_i` in 32: addend for MADD, bf16 in [31:16].
- `req_tag_i` in 5: destination register tag.
- `fpu_operator_o` out `fp_alu_op_e`: to FPU `operator_i`.
- `fpu_operand_a_o` out 32: to FPU `operand_a_i`.
- `fpu_operand_b_o` out 16: to FPU `operand_b_i`.
- `fpu_mode_o` out 2: to FPU `mode_i`.
- `fpu_result_i` in 32: from FPU `result_o`.
- `rsp_valid_o` out 1: result available.
- `rsp_ready_i` in 1: consumer takes the result.
- `rsp_result_o` out 32: result.
- `rsp_tag_o` out 5: tag of the request.
- `busy_o` out 1: high whenever the state is not IDLE.

## Operation
- **States:**
  - IDLE: waiting for a request.
  - EXEC: first FPU pass.
  - MADD2: add pass of MADD.
  - RESP: result held for the consumer.
- **Accept:** a request is accepted when `req_valid_i && req_ready_o`. On accept, latch op, mode, a, b[31:16], c[31:16] and tag, then go to EXEC.
- **`req_ready_o`:** equals `!flush_i && rst_ni && (IDLE || (RESP && rsp_ready_i))`. Accepting in RESP while the response is consumed gives back-to-back issue with no bubble.
- **EXEC, non-MADD:**
  - Drive `fpu_operator_o`=op, `fpu_operand_a_o`=a, `fpu_operand_b_o`=b16, `fpu_mode_o`=mode.
  - Capture `fpu_result_i` into the result register.
  - Next state RESP.
- **EXEC, MADD:**
  - Drive operator FP_ALU_MUL with a and b16, mode=0.
  - Capture `fpu_result_i[31:16]` as the product.
  - Next state MADD2.
- **MADD2:**
  - Drive operator FP_ALU_ADD, `fpu_operand_a_o`={product,16'h0}, `fpu_operand_b_o`=c16, mode=0.
  - Capture the result.
  - Next state RESP.
  - Rounding is that of two separate bf16 operations, not fused.
- **RESP:**
  - `rsp_valid_o`=1; `rsp_result_o` and `rsp_tag_o` are held stable until `rsp_ready_i`.
  - On handshake: go to EXEC if a new request is accepted in the same cycle, otherwise IDLE.
- **IDLE and RESP FPU drive:** `fpu_*_o` are driven to 0 (operator FP_ALU_ADD, operands 0).
- **Pass-through ops:** SUB, MINMAX, SGNJ, CMP, CVT, CLASS and undefined encodings go through the FPU unmodified; whatever the FPU returns (0 for MINMAX/undefined) is the result.
- **`flush_i`:**
  - From any state, the next state is IDLE.
  - No response is produced; `rsp_valid_o` drops the cycle after.
  - No request is accepted in a flush cycle.
  - If flush coincides with a RESP handshake, the handshake completes (the consumer already took the result), but no new request is accepted.
- **Reset:** applies on the clock edge with `rst_ni`=0; any in-flight request is lost.

## Timing
- **Reset values:**
  - state IDLE; `rsp_valid_o`=0, `rsp_result_o`=0, `rsp_tag_o`=0, `busy_o`=0.
  - `fpu_*_o`=0; `req_ready_o`=0 while `rst_ni`=0, and 1 in the first cycle after reset.
- **Non-MADD latency:** accept at edge N; EXEC in cycle N..N+1; `rsp_valid_o` high from edge N+1 (2 cycles from the request cycle).
- **MADD latency:** `rsp_valid_o` high from edge N+2 (one extra cycle).
- **Throughput:** with `rsp_ready_i` held high, one non-MADD result every 2 cycles and one MADD every 3.
- **Timing path:** the FPU is combinational, so `fpu_*_o` must come only from registers, giving a single FPU traversal per cycle.
- **Protocol:** `rsp_valid_o` never deasserts without a handshake, except on flush or reset.

## Test plan
- **ADD:** a=0x3F800000 (1.0), b=0x40000000 (2.0), tag=3 -> `rsp_valid_o` at request cycle +2 with result 0x40400000 and tag 3; FPU sees operator ADD, b16=0x4000.
- **MADD:** a=0x40000000 (2.0), b=0x40400000 (3.0), c=0x3F800000 (1.0) -> EXEC drives MUL, MADD2 drives ADD with a=0x40C00000 and b16=0x3F80; result 0x40E00000 (7.0) at +3.
- **Backpressure:** `rsp_ready_i`=0 for 5 cycles after a CLASS request on 0x7F800000 -> `rsp_result_o` stable and `req_ready_o`=0 throughout; on release, exactly one handshake occurs.
- **Back-to-back:** three SUB requests with `req_valid_i` and `rsp_ready_i` held high -> responses on consecutive even cycles, tags in order, no bubbles beyond EXEC.
- **Flush:** `flush_i` pulsed in MADD2 -> no response, IDLE next cycle, and the next ADD request completes normally.
- **Reset mid-EXEC:** `rst_ni`=0 for one edge during EXEC -> all outputs at reset values; no stale response after reset.
